// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl: sequential K-nearest-neighbour search over a dataset fetched point by point
module knn_seq_ctrl #(
    parameter int DATA_W    = 32,
    parameter int S         = 16,
    parameter int K         = 4,
    parameter int DATA_INFO = 40,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    test_point,
    input  logic [ADDR_W-1:0]    n_points,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_INFO-1:0] mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 busy,
    output logic                 done,
    input  logic [$clog2(K)-1:0] res_sel,
    output logic                 res_valid,
    output logic [DATA_W-1:0]    res_dist,
    output logic [7:0]           res_label
);
    localparam int KW = $clog2(K);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, INSERT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        tp_q, tp_d;
    logic [ADDR_W-1:0]        n_q, n_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [DATA_INFO-1:0]     data_q, data_d;
    logic [DATA_W-1:0]        dist_q, dist_d;
    logic                     mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [K-1:0]             ev_q, ev_d;
    logic [K-1:0][DATA_W-1:0] ed_q, ed_d;
    logic [K-1:0][7:0]        el_q, el_d;

    logic [S-1:0]   tx, ty, px, py, dx, dy;
    logic [2*S-1:0] dx2, dy2;
    logic [2*S:0]   sum;
    logic [DATA_W-1:0] dist_c;
    logic           found;
    logic [KW-1:0]  pos;
    logic [ADDR_W-1:0] idx_inc;

    assign tx      = tp_q[2*S-1:S];
    assign ty      = tp_q[S-1:0];
    assign px      = data_q[DATA_INFO-1 -: S];
    assign py      = data_q[DATA_INFO-1-S -: S];
    assign idx_inc = idx_q + ADDR_W'(1);

    // squared euclidean distance of the captured point, saturated to all-ones when the 33-bit sum overflows
    always_comb begin
        dx     = tx >= px ? tx - px : px - tx;
        dy     = ty >= py ? ty - py : py - ty;
        dx2    = {{S{1'b0}}, dx} * {{S{1'b0}}, dx};
        dy2    = {{S{1'b0}}, dy} * {{S{1'b0}}, dy};
        sum    = {1'b0, dx2} + {1'b0, dy2};
        dist_c = sum[2*S] ? '1 : sum[DATA_W-1:0];
    end

    // lowest rank that the new distance displaces; strict compare keeps earlier points ahead on ties
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (!ev_q[i] || dist_q < ed_q[i]) begin
                found = 1'b1;
                pos   = KW'(i);
            end
        end
    end

    // next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        tp_d    = tp_q;
        n_d     = n_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dist_d  = dist_q;
        ev_d    = ev_q;
        ed_d    = ed_q;
        el_d    = el_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tp_d    = test_point;
                    n_d     = n_points;
                    idx_d   = '0;
                    ev_d    = '0;
                    ed_d    = '1;
                    el_d    = '1;
                    state_d = n_points == '0 ? DONE : FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = CALC;
                end
            end
            CALC: begin
                dist_d  = dist_c;
                state_d = INSERT;
            end
            INSERT: begin
                for (int j = 0; j < K; j++) begin
                    if (found && j == int'(pos)) begin
                        ev_d[j] = 1'b1;
                        ed_d[j] = dist_q;
                        el_d[j] = data_q[7:0];
                    end
                end
                for (int j = 1; j < K; j++) begin
                    if (found && j > int'(pos)) begin
                        ev_d[j] = ev_q[j-1];
                        ed_d[j] = ed_q[j-1];
                        el_d[j] = el_q[j-1];
                    end
                end
                idx_d   = idx_inc;
                state_d = idx_inc == n_q ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d  = state_d == FETCH;
        mem_addr_d = idx_d;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
    end

    // state and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tp_q       <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            dist_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ev_q       <= '0;
            ed_q       <= '1;
            el_q       <= '1;
        end else begin
            state_q    <= state_d;
            tp_q       <= tp_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            dist_q     <= dist_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ev_q       <= ev_d;
            ed_q       <= ed_d;
            el_q       <= el_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = ev_q[res_sel];
    assign res_dist  = ed_q[res_sel];
    assign res_label = el_q[res_sel];
endmodule
